// File: rtl/booth_pkg.sv
// Shared types and helpers for the radix-4 Booth multiplier.
package booth_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } state_e;

  // Partial-product selection produced by the Booth recoder
  typedef enum logic [2:0] {
    SelZero,
    SelPm,
    SelP2m,
    SelNm,
    SelN2m
  } sel_e;

  // Number of radix-4 steps needed to consume an (n+2)-bit extended multiplier
  function automatic int unsigned iter_count(input int unsigned n);
    return n / 2 + 1;
  endfunction

endpackage

// File: rtl/booth_r4_recoder.sv
// Combinational modified-Booth recoder: maps {q1, q0, q_m1} to a partial-product select.
module booth_r4_recoder
  import booth_pkg::*;
(
  input  logic [2:0] triple,
  output sel_e       sel
);

  always_comb begin
    sel = SelZero;
    unique case (triple)
      3'b001, 3'b010: sel = SelPm;
      3'b011:         sel = SelP2m;
      3'b100:         sel = SelN2m;
      3'b101, 3'b110: sel = SelNm;
      default:        sel = SelZero;
    endcase
  end

endmodule

// File: rtl/booth_radix4_mult.sv
// Sequential radix-4 Booth multiplier, signed or unsigned, two multiplier bits per clock.
module booth_radix4_mult
  import booth_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           signed_mode,
  input  logic [N-1:0]   multiplicand,
  input  logic [N-1:0]   multiplier,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int unsigned ITER = iter_count(N);
  localparam int unsigned W    = N + 2;
  localparam int unsigned CntW = $clog2(ITER + 1);

  state_e           state_q, state_d;
  logic [W:0]       a_q, a_d;
  logic [W:0]       m_q, m_d;
  logic [W-1:0]     q_q, q_d;
  logic             qm1_q, qm1_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [2*N-1:0]   prod_q, prod_d;

  sel_e             sel;
  logic [W:0]       term;
  logic [W:0]       sum;
  logic [2*W+1:0]   shifted;
  logic             m_ext, q_ext;

  booth_r4_recoder u_recoder (
    .triple ({q_q[1:0], qm1_q}),
    .sel    (sel)
  );

  always_comb begin
    term = '0;
    unique case (sel)
      SelPm:   term = m_q;
      SelP2m:  term = m_q << 1;
      SelNm:   term = -m_q;
      SelN2m:  term = -(m_q << 1);
      default: term = '0;
    endcase
  end

  // Arithmetic shift of {sum, Q, q_m1} by two, written out so the sign fill is explicit
  always_comb begin
    sum     = a_q + term;
    shifted = {{2{sum[W]}}, sum, q_q[W-1:1]};
  end

  assign m_ext = signed_mode & multiplicand[N-1];
  assign q_ext = signed_mode & multiplier[N-1];

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    m_d     = m_q;
    q_d     = q_q;
    qm1_d   = qm1_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StCalc;
          a_d     = '0;
          qm1_d   = 1'b0;
          cnt_d   = CntW'(ITER);
          m_d     = {{3{m_ext}}, multiplicand};
          q_d     = {{2{q_ext}}, multiplier};
        end
      end
      StCalc: begin
        a_d   = shifted[2*W+1:W+1];
        q_d   = shifted[W:1];
        qm1_d = shifted[0];
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = StDone;
          prod_d  = shifted[2*N:1];
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      a_q     <= '0;
      m_q     <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      cnt_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      m_q     <= m_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
    end
  end

  assign busy    = (state_q == StCalc);
  assign done    = (state_q == StDone);
  assign product = prod_q;

endmodule

// File: tb/tb_booth_radix4_mult.sv
// Self-checking bench for booth_radix4_mult at N=4, 8 and 16 against an integer reference.
module tb_booth_radix4_mult;

  logic clk = 1'b0;
  logic reset;

  logic        start4, sm4, busy4, done4;
  logic [3:0]  a4, b4;
  logic [7:0]  p4;
  logic        start8, sm8, busy8, done8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;
  logic        start16, sm16, busy16, done16;
  logic [15:0] a16, b16;
  logic [31:0] p16;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  booth_radix4_mult #(.N(4)) u_dut4 (
    .clk(clk), .reset(reset), .start(start4), .signed_mode(sm4), .multiplicand(a4),
    .multiplier(b4), .busy(busy4), .done(done4), .product(p4)
  );

  booth_radix4_mult #(.N(8)) u_dut8 (
    .clk(clk), .reset(reset), .start(start8), .signed_mode(sm8), .multiplicand(a8),
    .multiplier(b8), .busy(busy8), .done(done8), .product(p8)
  );

  booth_radix4_mult #(.N(16)) u_dut16 (
    .clk(clk), .reset(reset), .start(start16), .signed_mode(sm16), .multiplicand(a16),
    .multiplier(b16), .busy(busy16), .done(done16), .product(p16)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer multiply of the interpreted operands, truncated to 2n bits
  function automatic logic [31:0] ref_mul(input int n, input logic sm, input logic [15:0] a,
                                          input logic [15:0] b);
    longint mask, x, y, p;
    mask = (longint'(1) << n) - 1;
    x = longint'(a) & mask;
    y = longint'(b) & mask;
    if (sm && x[n-1]) x = x - (mask + 1);
    if (sm && y[n-1]) y = y - (mask + 1);
    p = (x * y) & ((longint'(1) << (2 * n)) - 1);
    return p[31:0];
  endfunction

  function automatic logic dut_done(input int n);
    case (n)
      4:       return done4;
      16:      return done16;
      default: return done8;
    endcase
  endfunction

  function automatic logic dut_busy(input int n);
    case (n)
      4:       return busy4;
      16:      return busy16;
      default: return busy8;
    endcase
  endfunction

  function automatic logic [31:0] dut_prod(input int n);
    case (n)
      4:       return {24'b0, p4};
      16:      return p16;
      default: return {16'b0, p8};
    endcase
  endfunction

  task automatic drive(input int n, input logic s, input logic sm, input logic [15:0] a,
                       input logic [15:0] b);
    case (n)
      4:       begin start4 = s;  sm4 = sm;  a4 = a[3:0];  b4 = b[3:0];  end
      16:      begin start16 = s; sm16 = sm; a16 = a;      b16 = b;      end
      default: begin start8 = s;  sm8 = sm;  a8 = a[7:0];  b8 = b[7:0];  end
    endcase
  endtask

  // Called #1 after the accepting edge; returns #1 after the edge that raises done
  task automatic wait_done(input int n, output int lat, output int nbusy, output bit ov);
    lat = 0;
    nbusy = 0;
    ov = 1'b0;
    while (!dut_done(n) && lat < 40) begin
      if (dut_busy(n)) nbusy++;
      @(posedge clk); #1;
      lat++;
    end
    if (dut_busy(n) && dut_done(n)) ov = 1'b1;
  endtask

  task automatic mul_op(input int n, input logic sm, input logic [15:0] a, input logic [15:0] b,
                        output logic [31:0] p, output int lat, output int nbusy, output bit ov);
    drive(n, 1'b1, sm, a, b);
    @(posedge clk); #1;
    drive(n, 1'b0, sm, a, b);
    wait_done(n, lat, nbusy, ov);
    p = dut_prod(n);
    @(posedge clk); #1;
  endtask

  task automatic run_check(input int n, input logic sm, input logic [15:0] a,
                           input logic [15:0] b, input string tag);
    logic [31:0] p;
    int lat, nb;
    bit ov;
    mul_op(n, sm, a, b, p, lat, nb, ov);
    check_eq($sformatf("%s product %0h*%0h sm=%0b", tag, a, b, sm), p, ref_mul(n, sm, a, b));
    check_eq({tag, " latency"}, 32'(lat), 32'(n / 2 + 1));
    check_eq({tag, " busy_cycles"}, 32'(nb), 32'(n / 2 + 1));
    check_eq({tag, " busy_done_overlap"}, 32'(ov), 32'd0);
  endtask

  task automatic directed(input logic sm, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] exp, input string tag);
    logic [31:0] p;
    int lat, nb;
    bit ov;
    mul_op(8, sm, a, b, p, lat, nb, ov);
    check_eq({tag, " product"}, p, {16'b0, exp});
    check_eq({tag, " latency"}, 32'(lat), 32'd5);
    check_eq({tag, " busy_cycles"}, 32'(nb), 32'd5);
    check_eq({tag, " busy_done_overlap"}, 32'(ov), 32'd0);
  endtask

  initial begin
    logic [31:0] p;
    int lat, nb;
    bit ov;

    reset = 1'b1;
    drive(4, 1'b0, 1'b0, 16'h0, 16'h0);
    drive(8, 1'b0, 1'b0, 16'h0, 16'h0);
    drive(16, 1'b0, 1'b0, 16'h0, 16'h0);
    @(posedge clk); @(posedge clk); #1;
    check_eq("reset busy", 32'(busy8), 32'd0);
    check_eq("reset done", 32'(done8), 32'd0);
    check_eq("reset product", 32'(p8), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    directed(1'b1, 16'h0080, 16'h0080, 16'h4000, "s -128*-128");
    directed(1'b1, 16'h007F, 16'h00FF, 16'hFF81, "s 127*-1");
    directed(1'b0, 16'h00FF, 16'h00FF, 16'hFE01, "u 255*255");
    directed(1'b0, 16'h0000, 16'h00C8, 16'h0000, "u 0*200");

    // start held high, operands changed after acceptance
    drive(8, 1'b1, 1'b1, 16'd7, 16'd9);
    @(posedge clk); #1;
    drive(8, 1'b1, 1'b0, 16'h00F0, 16'd3);
    wait_done(8, lat, nb, ov);
    check_eq("held start latency", 32'(lat), 32'd5);
    check_eq("held start product", 32'(p8), 32'h003F);
    @(posedge clk); #1;
    check_eq("held start idle gap busy", 32'(busy8), 32'd0);
    check_eq("held start idle gap done", 32'(done8), 32'd0);
    drive(8, 1'b1, 1'b1, 16'h00F0, 16'd3);
    @(posedge clk); #1;
    check_eq("held start reaccept busy", 32'(busy8), 32'd1);
    drive(8, 1'b0, 1'b1, 16'h00F0, 16'd3);
    wait_done(8, lat, nb, ov);
    check_eq("second op product", 32'(p8), 32'h0000FFD0);
    @(posedge clk); #1;

    // reset during the third CALC cycle
    drive(8, 1'b1, 1'b1, 16'h0055, 16'h0033);
    @(posedge clk); #1;
    drive(8, 1'b0, 1'b1, 16'h0055, 16'h0033);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check_eq("mid reset busy", 32'(busy8), 32'd0);
    check_eq("mid reset done", 32'(done8), 32'd0);
    check_eq("mid reset product", 32'(p8), 32'd0);
    reset = 1'b0;
    directed(1'b1, 16'd3, 16'd5, 16'h000F, "s 3*5 after reset");

    // reset wins over a simultaneous start
    reset = 1'b1;
    drive(8, 1'b1, 1'b1, 16'd3, 16'd5);
    @(posedge clk); #1;
    check_eq("reset+start busy", 32'(busy8), 32'd0);
    reset = 1'b0;
    drive(8, 1'b0, 1'b1, 16'd3, 16'd5);
    @(posedge clk); #1;
    check_eq("reset+start busy later", 32'(busy8), 32'd0);
    check_eq("reset+start done later", 32'(done8), 32'd0);

    for (int s = 0; s < 2; s++)
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++)
          run_check(4, s[0], 16'(a), 16'(b), "n4");

    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 1500; i++)
        run_check(8, s[0], 16'($urandom()), 16'($urandom()), "n8");

    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 1000; i++)
        run_check(16, s[0], 16'($urandom()), 16'($urandom()), "n16");

    run_check(16, 1'b1, 16'h8000, 16'h8000, "n16 corner");
    run_check(16, 1'b0, 16'hFFFF, 16'hFFFF, "n16 corner");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
